// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared constants and types for the 16-bit pipelined MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          WIDTH     = 16;
    localparam int          PC_INC    = 2;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Fetch redirect FSM: RUN fetches normally, PEND holds a buffered branch target
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

    // Next-PC source selection
    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_PEND = 2'd2,
        SEL_HOLD = 2'd3
    } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Fetch-stage bus: hazard/branch controls, imem port, IF/ID outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int WIDTH = mips_pkg::WIDTH
);

    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] ifid_instr;
    logic [WIDTH-1:0] ifid_pc_plus;
    logic             ifid_valid;
    logic             redirect_pending;
    logic             misalign_err;

    modport master (
        input  stall,
        input  br_taken,
        input  br_target,
        input  imem_data,
        output imem_addr,
        output ifid_instr,
        output ifid_pc_plus,
        output ifid_valid,
        output redirect_pending,
        output misalign_err
    );

    modport slave (
        output stall,
        output br_taken,
        output br_target,
        output imem_data,
        input  imem_addr,
        input  ifid_instr,
        input  ifid_pc_plus,
        input  ifid_valid,
        input  redirect_pending,
        input  misalign_err
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_mux
// Brief    : Combinational next-PC select and PC+PC_INC adder.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import mips_pkg::pc_sel_t, mips_pkg::SEL_SEQ, mips_pkg::SEL_BR,
           mips_pkg::SEL_PEND, mips_pkg::SEL_HOLD;
#(
    parameter int WIDTH  = 16,
    parameter int PC_INC = 2
) (
    input  pc_sel_t          sel,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] pend_target,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc_plus
);

    localparam logic [WIDTH-1:0] C_INC = WIDTH'(PC_INC);

    // Wraps modulo 2^WIDTH by construction
    assign pc_plus = pc + C_INC;

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_SEQ:  pc_next = pc_plus;
            SEL_BR:   pc_next = {br_target[WIDTH-1:1], 1'b0};
            SEL_PEND: pc_next = pend_target;
            SEL_HOLD: pc_next = pc;
            default:  pc_next = pc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC register, redirect FSM and IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::fetch_state_t, mips_pkg::RUN, mips_pkg::PEND,
           mips_pkg::pc_sel_t, mips_pkg::SEL_SEQ, mips_pkg::SEL_BR,
           mips_pkg::SEL_PEND, mips_pkg::SEL_HOLD, mips_pkg::NOP_INSTR;
#(
    parameter int               WIDTH    = mips_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int               PC_INC   = mips_pkg::PC_INC
) (
    input  logic          clk,
    input  logic          clr,
    fetch_stage_if.master bus
);

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_target;
    logic [WIDTH-1:0] r_ifid_instr;
    logic [WIDTH-1:0] r_ifid_pc_plus;
    logic             r_ifid_valid;
    logic             r_redirect_pending;
    logic             r_misalign_err;

    pc_sel_t          w_sel;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_br_aligned;

    assign w_br_aligned = {bus.br_target[WIDTH-1:1], 1'b0};

    // A same-cycle branch always beats the buffered target on stall release
    always_comb begin
        w_sel = SEL_HOLD;
        case (r_state)
            RUN: begin
                if (!bus.stall) begin
                    w_sel = bus.br_taken ? SEL_BR : SEL_SEQ;
                end
            end
            PEND: begin
                if (!bus.stall) begin
                    w_sel = bus.br_taken ? SEL_BR : SEL_PEND;
                end
            end
            default: w_sel = SEL_HOLD;
        endcase
    end

    pc_next_mux #(
        .WIDTH  (WIDTH),
        .PC_INC (PC_INC)
    ) u_pc_next_mux (
        .sel         (w_sel),
        .pc          (r_pc),
        .br_target   (bus.br_target),
        .pend_target (r_pend_target),
        .pc_next     (w_pc_next),
        .pc_plus     (w_pc_plus)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state            <= RUN;
            r_pc               <= RESET_PC;
            r_pend_target      <= '0;
            r_ifid_instr       <= NOP_INSTR;
            r_ifid_pc_plus     <= '0;
            r_ifid_valid       <= 1'b0;
            r_redirect_pending <= 1'b0;
            r_misalign_err     <= 1'b0;
        end else begin
            r_pc <= w_pc_next;

            if (bus.br_taken && bus.br_target[0]) begin
                r_misalign_err <= 1'b1;
            end

            case (r_state)
                RUN: begin
                    if (bus.br_taken) begin
                        // Flush beats stall; pc_plus deliberately left untouched
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                        if (bus.stall) begin
                            r_pend_target      <= w_br_aligned;
                            r_state            <= PEND;
                            r_redirect_pending <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        r_ifid_instr   <= bus.imem_data;
                        r_ifid_pc_plus <= w_pc_plus;
                        r_ifid_valid   <= 1'b1;
                    end
                end
                PEND: begin
                    if (bus.stall) begin
                        if (bus.br_taken) begin
                            r_pend_target <= w_br_aligned;
                        end
                    end else begin
                        r_ifid_instr       <= NOP_INSTR;
                        r_ifid_valid       <= 1'b0;
                        r_state            <= RUN;
                        r_redirect_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state            <= RUN;
                    r_redirect_pending <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr        = r_pc;
    assign bus.ifid_instr       = r_ifid_instr;
    assign bus.ifid_pc_plus     = r_ifid_pc_plus;
    assign bus.ifid_valid       = r_ifid_valid;
    assign bus.redirect_pending = r_redirect_pending;
    assign bus.misalign_err     = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic saw_100  = 1'b0;

    fetch_stage_if #(.WIDTH(16)) bus ();

    fetch_stage dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: data = addr ^ A5A5
    assign bus.imem_data = bus.imem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (clr && bus.imem_addr == 16'h0100) saw_100 <= 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},  bus.imem_addr,        16'h0000);
        check({tag, "_instr"}, bus.ifid_instr,       16'h0000);
        check({tag, "_pcp"},   bus.ifid_pc_plus,     16'h0000);
        check({tag, "_valid"}, {15'd0, bus.ifid_valid},       16'd0);
        check({tag, "_pend"},  {15'd0, bus.redirect_pending}, 16'd0);
        check({tag, "_mis"},   {15'd0, bus.misalign_err},     16'd0);
    endtask

    initial begin
        bus.stall     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        clr = 1'b1;

        // Free run from RESET_PC
        step();
        check("run1_instr", bus.ifid_instr,   16'hA5A5);
        check("run1_pcp",   bus.ifid_pc_plus, 16'h0002);
        check("run1_valid", {15'd0, bus.ifid_valid}, 16'd1);
        check("run1_addr",  bus.imem_addr,    16'h0002);
        step();
        check("run2_instr", bus.ifid_instr,   16'hA5A7);
        check("run2_addr",  bus.imem_addr,    16'h0004);
        repeat (6) step();
        check("run8_addr",  bus.imem_addr,    16'h0010);

        // Unstalled branch to 0x0040 from PC 0x0010
        bus.br_taken = 1'b1; bus.br_target = 16'h0040;
        step();
        bus.br_taken = 1'b0;
        check("br_addr",    bus.imem_addr,    16'h0040);
        check("br_valid",   {15'd0, bus.ifid_valid}, 16'd0);
        check("br_instr",   bus.ifid_instr,   16'h0000);
        check("br_pcp",     bus.ifid_pc_plus, 16'h0010);
        step();
        check("brt_instr",  bus.ifid_instr,   16'hA5E5);
        check("brt_pcp",    bus.ifid_pc_plus, 16'h0042);
        check("brt_valid",  {15'd0, bus.ifid_valid}, 16'd1);

        // Stall three cycles with two branches; latest wins
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 16'h0100;
        step();
        check("st1_pend",   {15'd0, bus.redirect_pending}, 16'd1);
        check("st1_addr",   bus.imem_addr,    16'h0042);
        check("st1_valid",  {15'd0, bus.ifid_valid}, 16'd0);
        bus.br_target = 16'h0200;
        step();
        check("st2_pend",   {15'd0, bus.redirect_pending}, 16'd1);
        check("st2_addr",   bus.imem_addr,    16'h0042);
        bus.br_taken = 1'b0;
        step();
        check("st3_pend",   {15'd0, bus.redirect_pending}, 16'd1);
        check("st3_addr",   bus.imem_addr,    16'h0042);
        bus.stall = 1'b0;
        step();
        check("rel_addr",   bus.imem_addr,    16'h0200);
        check("rel_pend",   {15'd0, bus.redirect_pending}, 16'd0);
        check("rel_valid",  {15'd0, bus.ifid_valid}, 16'd0);
        step();
        check("rel2_instr", bus.ifid_instr,   16'hA7A5);
        check("rel2_pcp",   bus.ifid_pc_plus, 16'h0202);
        check("rel2_valid", {15'd0, bus.ifid_valid}, 16'd1);
        check("no_0100",    {15'd0, saw_100}, 16'd0);

        // Wrap-around at the top of the address space
        bus.br_taken = 1'b1; bus.br_target = 16'hFFFC;
        step();
        bus.br_taken = 1'b0;
        check("wr_addr0",   bus.imem_addr,    16'hFFFC);
        step();
        check("wr_addr1",   bus.imem_addr,    16'hFFFE);
        check("wr_instr1",  bus.ifid_instr,   16'h5A59);
        check("wr_pcp1",    bus.ifid_pc_plus, 16'hFFFE);
        step();
        check("wr_addr2",   bus.imem_addr,    16'h0000);
        check("wr_instr2",  bus.ifid_instr,   16'h5A5B);
        check("wr_pcp2",    bus.ifid_pc_plus, 16'h0000);

        // Misaligned target: forced even, sticky error
        check("mis_pre",    {15'd0, bus.misalign_err}, 16'd0);
        bus.br_taken = 1'b1; bus.br_target = 16'h0081;
        step();
        check("mis_addr",   bus.imem_addr,    16'h0080);
        check("mis_set",    {15'd0, bus.misalign_err}, 16'd1);
        bus.br_target = 16'h0010;
        step();
        bus.br_taken = 1'b0;
        check("mis_addr2",  bus.imem_addr,    16'h0010);
        check("mis_stick1", {15'd0, bus.misalign_err}, 16'd1);
        step();
        check("mis_stick2", {15'd0, bus.misalign_err}, 16'd1);

        // Asynchronous reset mid-cycle while in PEND
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 16'h0300;
        step();
        check("pnd_pend",   {15'd0, bus.redirect_pending}, 16'd1);
        #3;
        clr = 1'b0;
        #1;
        check_reset("arst");
        bus.stall = 1'b0; bus.br_taken = 1'b0;
        step();
        check_reset("arst_hold");
        clr = 1'b1;
        step();
        check("post_instr", bus.ifid_instr,   16'hA5A5);
        check("post_pcp",   bus.ifid_pc_plus, 16'h0002);
        check("post_valid", {15'd0, bus.ifid_valid}, 16'd1);
        check("post_addr",  bus.imem_addr,    16'h0002);
        check("post_pend",  {15'd0, bus.redirect_pending}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined MIPS core. It holds the program counter, drives the instruction-memory address, and registers the fetched instruction with its PC+2 into the IF/ID pipeline register. Its `ifid_pc_plus` output is the sequential-PC operand of the downstream branch adder. It accepts the resolved branch target back from that adder and redirects fetch.

## Interface
- `WIDTH`, 16: PC, address and instruction width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `PC_INC`, 2: sequential PC increment (byte-addressed, halfword instructions).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `clr`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  hazard unit: hold PC and IF/ID register.
- `br_taken`  in  1  branch resolved taken this cycle.
- `br_target`  in  WIDTH  branch adder result R.
- `imem_data`  in  WIDTH  instruction at `imem_addr`; combinational read.
- `imem_addr`  out  WIDTH  current PC.
- `ifid_instr`  out  WIDTH  registered instruction.
- `ifid_pc_plus`  out  WIDTH  registered PC+PC_INC of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `redirect_pending`  out  1  branch target buffered, waiting for stall release.
- `misalign_err`  out  1  sticky: an odd `br_target` was received.

## Operation
- FSM has two states: RUN and PEND. It resets to RUN.
- In RUN with no stall and no `br_taken`, each edge does: PC <= PC+PC_INC; IF/ID <= {imem_data, PC+PC_INC, valid=1}.
- In RUN with `br_taken` and no `stall`, the edge does: PC <= {br_target[15:1],1'b0}; IF/ID flushed (ifid_instr=0/NOP, ifid_valid=0, ifid_pc_plus unchanged). State stays RUN.
- In RUN with `br_taken` and `stall`, the edge does:
  - target captured into the pending register; state goes to PEND.
  - PC holds.
  - IF/ID is flushed. Flush beats stall.
- In RUN with `stall` only, PC and IF/ID hold.
- In PEND with `stall` still high, everything holds. A new `br_taken` overwrites the pending target, so the latest branch wins.
- In PEND with `stall` low, the edge does: PC <= pending target (a same-cycle `br_taken` target takes precedence); IF/ID stays flushed; state goes to RUN.
- Arithmetic is modulo 2^WIDTH: PC 16'hFFFE + 2 = 16'h0000, with no flag.
- Alignment: `br_target[0]`=1 with `br_taken` sets `misalign_err`. It is cleared only by reset, and the target is still used with bit 0 forced to 0.

## Timing
- Reset values while `clr`=0 (applied immediately, asynchronously):
  - PC=`imem_addr`=RESET_PC.
  - ifid_instr=0, ifid_pc_plus=0, ifid_valid=0.
  - redirect_pending=0, misalign_err=0.
  - state RUN, pending target dropped.
- Fetch latency is 1 edge: the instruction at `imem_addr` before edge N appears on `ifid_*` after edge N.
- After `clr` rises, the first unstalled edge presents instr@RESET_PC with ifid_valid=1.
- Branch penalty:
  - `br_taken` sampled at edge N (unstalled) puts the target on `imem_addr` after N and a bubble on IF/ID after N.
  - The target instruction is valid on IF/ID after N+1.
- `redirect_pending` is a registered output that equals (state==PEND).
- Reset asserted in PEND discards the buffered redirect; fetch resumes at RESET_PC.

## Structure
- Shared package `mips_pkg` holds WIDTH, PC_INC, RESET_PC, the NOP encoding (16'h0000) and the FSM state typedef {RUN, PEND}.
- One sub-module, `pc_next_mux`. It is combinational: it selects between sequential PC, forced-aligned branch target, pending target, or held PC. It also produces PC+PC_INC.
- FSM, pending register, PC register and IF/ID register live in `fetch_stage`.

## Test plan
- Reset then free-run with imem_data=addr^16'hA5A5 → after edge 1: ifid_instr=16'hA5A5, ifid_pc_plus=0x0002, valid=1. Addresses then go 0,2,4,…
- Unstalled `br_taken` with br_target=0x0040 at PC=0x0010 → imem_addr=0x0040 next cycle; one bubble (valid=0); then ifid_pc_plus=0x0042, valid=1.
- `stall` for 3 cycles, with `br_taken` (0x0100) in the first of them and `br_taken` (0x0200) in the second → redirect_pending=1 and PC held throughout. After release, PC=0x0200 and 0x0100 is never fetched.
- PC=0xFFFC free-run → addresses 0xFFFC, 0xFFFE, 0x0000; ifid_pc_plus of 0xFFFE is 0x0000.
- br_target=0x0081 → PC=0x0080, misalign_err=1. It stays 1 through later branches and clears only on `clr`=0.
- Assert `clr` asynchronously mid-cycle while in PEND → all outputs immediately take their reset values. After release, the fetch starts at RESET_PC with redirect_pending=0.
